ita_output_fifo: RTL and testbench

// - Output buffer directly downstream of the activation/requantization stage. That stage has fixed latency and no backpressure.
// - Captures one requant_oup_t vector (N x WI bits) per valid cycle into a circular FIFO.
// - Drains the FIFO to the output stream with valid/ready handshake and a tile-last marker.
// - Asserts stall_o early enough that no vector still in the upstream pipeline is lost.

---
 rtl/ita_package.sv | 19 +
 rtl/ita_output_fifo_if.sv | 23 ++
 rtl/ita_output_fifo_ctrl.sv | 113 +++++++++++
 rtl/ita_output_fifo.sv | 53 +++++
 tb/tb_ita_output_fifo.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ita_package.sv
// Shared ITA types and constants used by the activation stage and the output FIFO.
package ita_package;

  localparam int unsigned N  = 4;
  localparam int unsigned WI = 8;

  typedef logic [N-1:0][WI-1:0] requant_oup_t;

  localparam int unsigned OutFifoDepth    = 8;
  localparam int unsigned OutFifoInFlight = 4;

  typedef logic [15:0] tile_len_t;

  // A programmed tile length of zero behaves like a length of one.
  function automatic tile_len_t effective_tile_len(input tile_len_t len);
    return (len == '0) ? tile_len_t'(1) : len;
  endfunction

endpackage

// File: rtl/ita_output_fifo_if.sv
// Stream bundle of the output FIFO: upstream capture side and downstream drain side.
interface ita_output_fifo_if;
  import ita_package::*;

  logic         valid_i;
  requant_oup_t data_i;
  logic         stall_o;
  logic         valid_o;
  logic         ready_i;
  requant_oup_t data_o;
  logic         last_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output stall_o, valid_o, data_o, last_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  stall_o, valid_o, data_o, last_o
  );

endinterface

// File: rtl/ita_output_fifo_ctrl.sv
// Output FIFO control: pointers, occupancy, early stall and tile-last tracking.
// Optional feature macro: ITA_OUTPUT_FIFO_OVERFLOW_CHECK_EN (sticky overflow flag + assertion).
module ita_output_fifo_ctrl
  import ita_package::*;
#(
  parameter int unsigned Depth    = OutFifoDepth,
  parameter int unsigned InFlight = OutFifoInFlight
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  tile_len_t                tile_len_i,
  input  logic                     valid_i,
  input  logic                     ready_i,
  output logic                     wr_en_o,
  output logic [$clog2(Depth)-1:0] wr_ptr_o,
  output logic [$clog2(Depth)-1:0] rd_ptr_o,
  output logic                     valid_o,
  output logic                     last_o,
  output logic                     stall_o,
  output logic                     overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull  = CntW'(Depth);
  localparam logic [CntW-1:0] CntStall = CntW'(Depth - InFlight);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  tile_len_t       tc_q, tc_d;
  tile_len_t       tile_len_q, len_cur;
  logic            stall_q;
  logic            full, push, pop, drop;

  assign full    = (count_q == CntFull);
  assign valid_o = (count_q != '0);
  assign pop     = valid_o && ready_i;
  assign push    = valid_i && (!full || pop);
  assign drop    = valid_i && full && !pop && !flush_i;
  assign wr_en_o = push && !flush_i;

  // While the tile counter sits at zero the live tile length applies; it is frozen once the tile starts.
  assign len_cur = (tc_q == '0) ? effective_tile_len(tile_len_i) : tile_len_q;
  assign last_o  = valid_o && (tc_q == (len_cur - tile_len_t'(1)));

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign stall_o  = stall_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tc_d     = tc_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      tc_d     = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        tc_d     = last_o ? '0 : tc_q + tile_len_t'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Stall is registered from the next-state count so it lines up with the count it describes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tc_q       <= '0;
      tile_len_q <= tile_len_t'(1);
      stall_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tc_q     <= tc_d;
      stall_q  <= (count_d >= CntStall);
      if (tc_q == '0) tile_len_q <= len_cur;
    end
  end

`ifdef ITA_OUTPUT_FIFO_OVERFLOW_CHECK_EN
  logic overflow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

  assign overflow_o = overflow_q;

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) !drop)
    else $warning("ita_output_fifo: push dropped, FIFO full");
`endif
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: rtl/ita_output_fifo.sv
// Output buffer behind the requantization stage: circular FIFO with first-word fall-through head.
// Optional feature macro: ITA_OUTPUT_FIFO_OVERFLOW_CHECK_EN (handled in ita_output_fifo_ctrl).
module ita_output_fifo
  import ita_package::*;
#(
  parameter int unsigned Depth    = OutFifoDepth,
  parameter int unsigned InFlight = OutFifoInFlight
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  tile_len_t            tile_len_i,
  ita_output_fifo_if.slave     io,
  output logic                 overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  requant_oup_t    mem_q [Depth];
  logic            wr_en;
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic            head_valid, head_last, stall;

  ita_output_fifo_ctrl #(
    .Depth    (Depth),
    .InFlight (InFlight)
  ) i_ctrl (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .tile_len_i (tile_len_i),
    .valid_i    (io.valid_i),
    .ready_i    (io.ready_i),
    .wr_en_o    (wr_en),
    .wr_ptr_o   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .valid_o    (head_valid),
    .last_o     (head_last),
    .stall_o    (stall),
    .overflow_o (overflow_o)
  );

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr] <= io.data_i;
  end

  assign io.data_o  = head_valid ? mem_q[rd_ptr] : '0;
  assign io.valid_o = head_valid;
  assign io.last_o  = head_last;
  assign io.stall_o = stall;

endmodule

// File: tb/tb_ita_output_fifo.sv
// Scoreboard bench for ita_output_fifo: queue-based reference model, directed corners plus random traffic.
module tb_ita_output_fifo;
  import ita_package::*;

  localparam int Depth    = OutFifoDepth;
  localparam int InFlight = OutFifoInFlight;
  localparam int W        = N * WI;
`ifdef ITA_OUTPUT_FIFO_OVERFLOW_CHECK_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic      clk_i = 1'b0;
  logic      rst_ni = 1'b0;
  logic      flush_i = 1'b0;
  logic      overflow_o;
  tile_len_t tile_len = 16'd3;

  ita_output_fifo_if fifo_if ();

  ita_output_fifo #(
    .Depth    (Depth),
    .InFlight (InFlight)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .tile_len_i (tile_len),
    .io         (fifo_if.slave),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: expected vectors in order, occupancy, sticky drop flag, position in tile.
  requant_oup_t exp_q[$];
  int           occ = 0;
  int           occ_start = 0;
  bit           ovf = 1'b0;
  bit           ovf_start = 1'b0;
  int           pos = 0;
  int           cur_len = 1;
  int           checks = 0;
  int           failures = 0;
  bit           mon_en = 1'b0;
  requant_oup_t first;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs and advances the model by that cycle's accepted push/pop.
  task automatic applyStimulus(input bit v, input bit r, input bit f, input requant_oup_t d);
    bit pop_m, push_m;
    @(posedge clk_i);
    #1;
    fifo_if.valid_i = v;
    fifo_if.ready_i = r;
    fifo_if.data_i  = d;
    flush_i         = f;
    occ_start = occ;
    ovf_start = ovf;
    if (f) begin
      exp_q.delete();
      occ = 0;
    end else begin
      pop_m  = (occ > 0) && r;
      push_m = v && ((occ < Depth) || pop_m);
      if (v && !push_m) ovf = 1'b1;
      occ = occ - int'(pop_m) + int'(push_m);
      if (push_m) exp_q.push_back(d);
    end
  endtask

  task automatic midReset();
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_valid_o", W'(fifo_if.valid_o), W'(0));
    checkOutput("rst_data_o", fifo_if.data_o, W'(0));
    checkOutput("rst_last_o", W'(fifo_if.last_o), W'(0));
    checkOutput("rst_stall_o", W'(fifo_if.stall_o), W'(0));
    checkOutput("rst_overflow_o", W'(overflow_o), W'(0));
    fifo_if.valid_i = 1'b0;
    fifo_if.ready_i = 1'b0;
    flush_i = 1'b0;
    exp_q.delete();
    occ = 0;
    occ_start = 0;
    ovf = 1'b0;
    ovf_start = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("drain_empty", W'(exp_q.size()), W'(0));
  endtask

  // Monitor: checks handshake-side outputs each cycle and pops the scoreboard on every transfer.
  always @(negedge clk_i) begin
    requant_oup_t exp_d;
    bit           exp_last;
    if (!rst_ni) begin
      pos = 0;
    end else if (mon_en) begin
      checkOutput("valid_o", W'(fifo_if.valid_o), W'(occ_start > 0));
      checkOutput("stall_o", W'(fifo_if.stall_o), W'((Depth - occ_start) <= InFlight));
      checkOutput("overflow_o", W'(overflow_o), W'(OvfEn & ovf_start));
      if (flush_i) begin
        pos = 0;
      end else if (fifo_if.valid_o && fifo_if.ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL pop_on_empty: got transfer of %h, expected no transfer", fifo_if.data_o);
        end else begin
          exp_d = exp_q.pop_front();
          if (pos == 0) cur_len = (tile_len == 16'd0) ? 1 : int'(tile_len);
          exp_last = (pos == cur_len - 1);
          checkOutput("data_o", fifo_if.data_o, exp_d);
          checkOutput("last_o", W'(fifo_if.last_o), W'(exp_last));
          pos = exp_last ? 0 : pos + 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fifo_if.valid_i = 1'b0;
    fifo_if.ready_i = 1'b0;
    fifo_if.data_i  = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset_valid_o", W'(fifo_if.valid_o), W'(0));
    checkOutput("reset_stall_o", W'(fifo_if.stall_o), W'(0));
    checkOutput("reset_data_o", fifo_if.data_o, W'(0));
    checkOutput("reset_last_o", W'(fifo_if.last_o), W'(0));
    checkOutput("reset_overflow_o", W'(overflow_o), W'(0));
    rst_ni = 1'b1;
    mon_en = 1'b1;
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, '0);

    // Fill to full with no drain; head must stay on the first vector, stall after four entries.
    first = requant_oup_t'($urandom);
    for (int i = 0; i < Depth; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, (i == 0) ? first : requant_oup_t'($urandom));
      if (occ_start > 0) checkOutput("data_hold", fifo_if.data_o, first);
      if (i == 3) checkOutput("stall_before_4", W'(fifo_if.stall_o), W'(0));
      if (i == 4) checkOutput("stall_after_4", W'(fifo_if.stall_o), W'(1));
    end

    // Push and pop together while full, then one push that must be dropped.
    applyStimulus(1'b1, 1'b1, 1'b0, requant_oup_t'($urandom));
    applyStimulus(1'b1, 1'b0, 1'b0, requant_oup_t'($urandom));
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("overflow_sticky", W'(overflow_o), W'(OvfEn));
    drain(Depth + 2);

    // Tile length 3 over seven vectors, then tile length 0.
    tile_len = 16'd3;
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b0, requant_oup_t'($urandom));
    drain(3);
    tile_len = 16'd0;
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, requant_oup_t'($urandom));
    drain(3);

    // Flush together with push and pop; overflow flag must survive.
    tile_len = 16'd3;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, requant_oup_t'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b1, requant_oup_t'($urandom));
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("flush_valid_o", W'(fifo_if.valid_o), W'(0));
    checkOutput("flush_keeps_ovf", W'(overflow_o), W'(OvfEn));
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, requant_oup_t'($urandom));
    drain(3);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, requant_oup_t'($urandom));
    midReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, requant_oup_t'($urandom));
    drain(3);

    // Random traffic with occasional flushes and tile length changes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) tile_len = tile_len_t'($urandom_range(0, 4));
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 49) == 0, requant_oup_t'($urandom));
    end
    drain(Depth + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
